// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multicycle core: ALU ops, opcodes, states.
// S_TRAP exists only when MIPS_MC_OF_TRAP_EN is defined.
package mips_pkg;

  localparam logic [2:0] AND_OP = 3'd0;
  localparam logic [2:0] OR_OP  = 3'd1;
  localparam logic [2:0] XOR_OP = 3'd2;
  localparam logic [2:0] NOR_OP = 3'd3;
  localparam logic [2:0] ADD_OP = 3'd4;
  localparam logic [2:0] SUB_OP = 3'd5;
  localparam logic [2:0] SLT_OP = 3'd6;
  localparam logic [2:0] SLL_OP = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] SRC_RT   = 2'd0;
  localparam logic [1:0] SRC_SEXT = 2'd1;
  localparam logic [1:0] SRC_ZEXT = 2'd2;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  typedef enum logic [3:0] {
    S_RST,
    S_IF,
    S_ID,
    S_EXR,
    S_WBR,
    S_EXI,
    S_WBI,
    S_ADR,
    S_MRD,
    S_WBM,
    S_MWR,
    S_BR,
`ifdef MIPS_MC_OF_TRAP_EN
    S_J,
    S_TRAP
`else
    S_J
`endif
  } state_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_src_b;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       rf_we;
    logic       rf_dst;
    logic       wb_sel;
    logic       mem_re;
    logic       mem_we;
    logic       ill;
    logic       trap;
  } ctrl_t;

  // Signed-overflow sensitive instructions: add, sub, addi.
  function automatic logic is_ov_op(input logic [5:0] op,
                                    input logic [5:0] fn);
    return (op == OP_ADDI) ||
           ((op == OP_RTYPE) && ((fn == FN_ADD) || (fn == FN_SUB)));
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// ALU operation / operand-B decode and legality check.
// Pure combinational; shared by ID legality and EX stages.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       legal
);

  logic [2:0] r_op;
  logic       r_ok;

  always_comb begin
    r_op = AND_OP;
    r_ok = 1'b1;
    unique case (1'b1)
      (funct == FN_ADD):  r_op = ADD_OP;
      (funct == FN_SUB):  r_op = SUB_OP;
      (funct == FN_AND):  r_op = AND_OP;
      (funct == FN_OR):   r_op = OR_OP;
      (funct == FN_XOR):  r_op = XOR_OP;
      (funct == FN_NOR):  r_op = NOR_OP;
      (funct == FN_SLT):  r_op = SLT_OP;
      (funct == FN_SLLV): r_op = SLL_OP;
      default:            r_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_op    = AND_OP;
    alu_src_b = SRC_RT;
    legal     = 1'b1;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        alu_op = r_op;
        legal  = r_ok;
      end
      (opcode == OP_ADDI): begin
        alu_op    = ADD_OP;
        alu_src_b = SRC_SEXT;
      end
      (opcode == OP_SLTI): begin
        alu_op    = SLT_OP;
        alu_src_b = SRC_SEXT;
      end
      (opcode == OP_ANDI): begin
        alu_op    = AND_OP;
        alu_src_b = SRC_ZEXT;
      end
      (opcode == OP_ORI): begin
        alu_op    = OR_OP;
        alu_src_b = SRC_ZEXT;
      end
      (opcode == OP_XORI): begin
        alu_op    = XOR_OP;
        alu_src_b = SRC_ZEXT;
      end
      (opcode == OP_LW),
      (opcode == OP_SW): begin
        alu_op    = ADD_OP;
        alu_src_b = SRC_SEXT;
      end
      (opcode == OP_BEQ),
      (opcode == OP_BNE): alu_op = SUB_OP;
      (opcode == OP_J):   alu_op = AND_OP;
      default:            legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle control FSM for the MIPS R/I/J core.
// Define MIPS_MC_OF_TRAP_EN for the sticky overflow trap.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zf,
  input  logic       of,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       rf_we,
  output logic       rf_dst,
  output logic       wb_sel,
  output logic       mem_re,
  output logic       mem_we,
  output logic       ill,
  output logic       trap
);

  state_t     state;
  state_t     nxt;
  ctrl_t      c;
  logic [5:0] op_q;
  logic [5:0] fn_q;
  logic [5:0] dec_op;
  logic [5:0] dec_fn;
  logic [2:0] d_alu_op;
  logic [1:0] d_src_b;
  logic       d_legal;
  logic       ov_trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= nxt;
  end

  // Freeze the instruction at ID exit so later IR changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      fn_q <= '0;
    end else if (state == S_ID) begin
      op_q <= opcode;
      fn_q <= funct;
    end
  end

  assign dec_op = (state == S_ID) ? opcode : op_q;
  assign dec_fn = (state == S_ID) ? funct  : fn_q;

  mips_alu_dec u_dec (
    .opcode    (dec_op),
    .funct     (dec_fn),
    .alu_op    (d_alu_op),
    .alu_src_b (d_src_b),
    .legal     (d_legal)
  );

`ifdef MIPS_MC_OF_TRAP_EN
  assign ov_trap = of && is_ov_op(op_q, fn_q);
`else
  logic unused_of;
  assign unused_of = of;
  assign ov_trap   = 1'b0;
`endif

  always_comb begin
    nxt = S_RST;
    unique case (state)
      S_RST: nxt = S_IF;
      S_IF:  nxt = S_ID;
      S_ID: begin
        nxt = S_IF;
        if (d_legal) begin
          unique case (1'b1)
            (dec_op == OP_RTYPE): nxt = S_EXR;
            (dec_op == OP_ADDI),
            (dec_op == OP_SLTI),
            (dec_op == OP_ANDI),
            (dec_op == OP_ORI),
            (dec_op == OP_XORI):  nxt = S_EXI;
            (dec_op == OP_LW),
            (dec_op == OP_SW):    nxt = S_ADR;
            (dec_op == OP_BEQ),
            (dec_op == OP_BNE):   nxt = S_BR;
            (dec_op == OP_J):     nxt = S_J;
            default:              nxt = S_IF;
          endcase
        end
      end
      S_EXR: nxt = S_WBR;
      S_EXI: nxt = S_WBI;
      S_WBR,
      S_WBI: begin
        nxt = S_IF;
`ifdef MIPS_MC_OF_TRAP_EN
        if (ov_trap) nxt = S_TRAP;
`endif
      end
      S_ADR: nxt = (op_q == OP_LW) ? S_MRD : S_MWR;
      S_MRD: nxt = S_WBM;
      S_WBM: nxt = S_IF;
      S_MWR: nxt = S_IF;
      S_BR:  nxt = S_IF;
      S_J:   nxt = S_IF;
`ifdef MIPS_MC_OF_TRAP_EN
      S_TRAP: nxt = S_TRAP;
`endif
      default: nxt = S_RST;
    endcase
  end

  always_comb begin
    c        = '0;
    c.alu_op = AND_OP;
    unique case (state)
      S_IF: begin
        c.ir_we  = 1'b1;
        c.pc_we  = 1'b1;
        c.pc_src = PC_SEQ;
      end
      S_ID: c.ill = ~d_legal;
      S_EXR,
      S_EXI: begin
        c.alu_op    = d_alu_op;
        c.alu_src_b = d_src_b;
      end
      S_WBR: begin
        c.alu_op    = d_alu_op;
        c.alu_src_b = d_src_b;
        c.rf_we     = ~ov_trap;
        c.rf_dst    = 1'b1;
        c.wb_sel    = WB_ALU;
      end
      S_WBI: begin
        c.alu_op    = d_alu_op;
        c.alu_src_b = d_src_b;
        c.rf_we     = ~ov_trap;
        c.rf_dst    = 1'b0;
        c.wb_sel    = WB_ALU;
      end
      S_ADR: begin
        c.alu_op    = ADD_OP;
        c.alu_src_b = SRC_SEXT;
      end
      S_MRD: begin
        c.alu_op    = ADD_OP;
        c.alu_src_b = SRC_SEXT;
        c.mem_re    = 1'b1;
      end
      S_MWR: begin
        c.alu_op    = ADD_OP;
        c.alu_src_b = SRC_SEXT;
        c.mem_we    = 1'b1;
      end
      S_WBM: begin
        c.rf_we  = 1'b1;
        c.wb_sel = WB_MEM;
      end
      // Only pc_we follows zf directly; all else is a state decode.
      S_BR: begin
        c.alu_op    = SUB_OP;
        c.alu_src_b = SRC_RT;
        c.pc_src    = PC_BR;
        c.pc_we     = (op_q == OP_BEQ) ? zf : ~zf;
      end
      S_J: begin
        c.pc_we  = 1'b1;
        c.pc_src = PC_JMP;
      end
`ifdef MIPS_MC_OF_TRAP_EN
      S_TRAP: c.trap = 1'b1;
`endif
      default: c = '0;
    endcase
  end

  assign alu_op    = c.alu_op;
  assign alu_src_b = c.alu_src_b;
  assign ir_we     = c.ir_we;
  assign pc_we     = c.pc_we;
  assign pc_src    = c.pc_src;
  assign rf_we     = c.rf_we;
  assign rf_dst    = c.rf_dst;
  assign wb_sel    = c.wb_sel;
  assign mem_re    = c.mem_re;
  assign mem_we    = c.mem_we;
  assign ill       = c.ill;
  assign trap      = c.trap;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-cycle expected control vectors.
// Honours MIPS_MC_OF_TRAP_EN for the overflow trap expectations.
module tb_mips_mc_ctrl;

`ifdef MIPS_MC_OF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zf;
  logic       of;
  logic [2:0] alu_op;
  logic [1:0] alu_src_b;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       rf_we;
  logic       rf_dst;
  logic       wb_sel;
  logic       mem_re;
  logic       mem_we;
  logic       ill;
  logic       trap;
  logic [15:0] outv;

  logic [15:0] exp_q[$];
  int n_cmp;
  int n_bad;

  mips_mc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct     (funct),
    .zf        (zf),
    .of        (of),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .rf_we     (rf_we),
    .rf_dst    (rf_dst),
    .wb_sel    (wb_sel),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .ill       (ill),
    .trap      (trap)
  );

  assign outv = {alu_op, alu_src_b, ir_we, pc_we, pc_src,
                 rf_we, rf_dst, wb_sel, mem_re, mem_we, ill, trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] vec(
    input logic [2:0] a, input logic [1:0] sb,
    input logic irw, input logic pcw, input logic [1:0] pcs,
    input logic rfw, input logic rfd, input logic wbs,
    input logic mre, input logic mwe, input logic il, input logic tr);
    return {a, sb, irw, pcw, pcs, rfw, rfd, wbs, mre, mwe, il, tr};
  endfunction

  // Reference model: expected vector for every cycle of one instruction.
  task automatic model(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic o);
    logic [2:0] a;
    logic [1:0] sb;
    logic ok;
    logic tc;
    a  = 3'd0;
    sb = 2'd0;
    ok = 1'b1;
    exp_q.push_back(vec(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    case (op)
      6'h00: case (fn)
        6'h20: a = 3'd4;
        6'h22: a = 3'd5;
        6'h24: a = 3'd0;
        6'h25: a = 3'd1;
        6'h26: a = 3'd2;
        6'h27: a = 3'd3;
        6'h2A: a = 3'd6;
        6'h04: a = 3'd7;
        default: ok = 1'b0;
      endcase
      6'h08: begin a = 3'd4; sb = 2'd1; end
      6'h0A: begin a = 3'd6; sb = 2'd1; end
      6'h0C: begin a = 3'd0; sb = 2'd2; end
      6'h0D: begin a = 3'd1; sb = 2'd2; end
      6'h0E: begin a = 3'd2; sb = 2'd2; end
      6'h23, 6'h2B, 6'h04, 6'h05, 6'h02: ;
      default: ok = 1'b0;
    endcase
    exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, !ok, 0));
    if (!ok) return;
    tc = TRAP_EN && o &&
         ((op == 6'h08) || (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)));
    case (op)
      6'h00: begin
        exp_q.push_back(vec(a, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(vec(a, 0, 0, 0, 0, !tc, 1, 0, 0, 0, 0, 0));
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
        exp_q.push_back(vec(a, sb, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(vec(a, sb, 0, 0, 0, !tc, 0, 0, 0, 0, 0, 0));
      end
      6'h23: begin
        exp_q.push_back(vec(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(vec(4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(vec(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      end
      6'h2B: begin
        exp_q.push_back(vec(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(vec(4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      end
      6'h04, 6'h05:
        exp_q.push_back(vec(5, 0, 0, (op == 6'h04) ? z : !z, 1,
                            0, 0, 0, 0, 0, 0, 0));
      default:
        exp_q.push_back(vec(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    endcase
    if (tc) repeat (3) exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  // Present a new instruction just after the edge that enters S_IF.
  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic o);
    @(posedge clk);
    #1;
    opcode = op;
    funct  = fn;
    zf     = z;
    of     = o;
    model(op, fn, z, o);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    opcode = 6'h00;
    funct  = 6'h20;
    zf     = 1'b0;
    of     = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (outv !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_out got %h exp %h", outv, 16'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [5:0] fns[8];
    logic [15:0] e;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h04};
    for (int i = 0; i < 8; i++) begin
      drive(6'h00, fns[i], 1'($urandom_range(0, 1)), 1'b0);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (outv !== e) begin
          n_bad++;
          $display("FAIL rtype fn=%h got %h exp %h", fns[i], outv, e);
        end
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0] ops[5];
    logic [15:0] e;
    ops = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], 6'h3F, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (outv !== e) begin
          n_bad++;
          $display("FAIL itype op=%h got %h exp %h", ops[i], outv, e);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      drive((i < 2) ? 6'h04 : 6'h05, 6'h00, 1'(i % 2), 1'b0);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (outv !== e) begin
          n_bad++;
          $display("FAIL branch case=%0d got %h exp %h", i, outv, e);
        end
      end
    end
  endtask

  task automatic test_jump_mem();
    logic [5:0] ops[3];
    logic [15:0] e;
    ops = '{6'h02, 6'h23, 6'h2B};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 6'h20, 1'b1, 1'b0);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (outv !== e) begin
          n_bad++;
          $display("FAIL jmp_mem op=%h got %h exp %h", ops[i], outv, e);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops[3];
    logic [5:0] fns[3];
    logic [15:0] e;
    ops = '{6'h3F, 6'h00, 6'h01};
    fns = '{6'h20, 6'h3F, 6'h00};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], fns[i], 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (outv !== e) begin
          n_bad++;
          $display("FAIL illegal op=%h fn=%h got %h exp %h",
                   ops[i], fns[i], outv, e);
        end
      end
    end
  endtask

  // IR changes after ID must not disturb the in-flight instruction.
  task automatic test_latch();
    logic [15:0] e;
    int k;
    drive(6'h00, 6'h22, 1'b0, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outv !== e) begin
        n_bad++;
        $display("FAIL latch cyc=%0d got %h exp %h", k, outv, e);
      end
      if (k == 1) begin
        @(posedge clk);
        #1;
        opcode = 6'h3F;
        funct  = 6'h00;
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[8];
    logic [5:0] fns[8];
    logic [15:0] e;
    int j;
    ops = '{6'h00, 6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05};
    fns = '{6'h25, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    for (int i = 0; i < 16; i++) begin
      j = int'($urandom_range(0, 7));
      drive(ops[j], fns[j], 1'($urandom_range(0, 1)), 1'b0);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (outv !== e) begin
          n_bad++;
          $display("FAIL b2b op=%h got %h exp %h", ops[j], outv, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    drive(6'h00, 6'h20, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outv !== e) begin
        n_bad++;
        $display("FAIL rmid_pre got %h exp %h", outv, e);
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rf_we !== 1'b0 || outv !== 16'h0) begin
      n_bad++;
      $display("FAIL rmid_drop got %h exp %h", outv, 16'h0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    opcode = 6'h00;
    funct  = 6'h24;
    zf     = 1'b0;
    of     = 1'b0;
    model(6'h00, 6'h24, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outv !== e) begin
        n_bad++;
        $display("FAIL rmid_post got %h exp %h", outv, e);
      end
    end
  endtask

  task automatic test_overflow();
    logic [5:0] ops[3];
    logic [5:0] fns[3];
    logic [15:0] e;
    ops = '{6'h08, 6'h00, 6'h00};
    fns = '{6'h00, 6'h20, 6'h26};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], fns[i], 1'b0, 1'b1);
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (outv !== e) begin
          n_bad++;
          $display("FAIL ovf op=%h fn=%h got %h exp %h",
                   ops[i], fns[i], outv, e);
        end
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (trap !== 1'b0 || outv !== 16'h0) begin
        n_bad++;
        $display("FAIL ovf_rst got %h exp %h", outv, 16'h0);
      end
      of = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_rtype();
    test_itype();
    test_branch();
    test_jump_mem();
    test_illegal();
    test_latch();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
